// File: rtl/fib_pkg.sv
// Shared types and constants for the additive sequence generator.
// Optional index counter is enabled by defining FIB_INDEX_EN.
package fib_pkg;

  typedef enum logic {
    RUN  = 1'b0,
    HALT = 1'b1
  } fib_state_e;

  localparam int FIB_SEED0 = 0;
  localparam int FIB_SEED1 = 1;

  localparam bit OVF_STOP = 1'b1;
  localparam bit OVF_WRAP = 1'b0;

endpackage

// File: rtl/fib_seq_gen_if.sv
// Control/data bundle between a sequence consumer (master) and fib_seq_gen (slave).
// The index signal exists only when FIB_INDEX_EN is defined.
interface fib_seq_gen_if #(
  parameter int WIDTH = 32
`ifdef FIB_INDEX_EN
  , parameter int IDX_W = 8
`endif
);
  logic             en;
  logic             load;
  logic [WIDTH-1:0] seed0;
  logic [WIDTH-1:0] seed1;
  logic [WIDTH-1:0] out;
  logic [WIDTH-1:0] nxt;
  logic             ovf;
  logic             done;
`ifdef FIB_INDEX_EN
  logic [IDX_W-1:0] index;

  modport master (output en, load, seed0, seed1,
                  input  out, nxt, ovf, done, index);
  modport slave  (input  en, load, seed0, seed1,
                  output out, nxt, ovf, done, index);
`else
  modport master (output en, load, seed0, seed1,
                  input  out, nxt, ovf, done);
  modport slave  (input  en, load, seed0, seed1,
                  output out, nxt, ovf, done);
`endif
endinterface

// File: rtl/fib_step.sv
// One term of an additive sequence: WIDTH-bit add with carry out.
module fib_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] sum,
  output logic             carry
);
  assign {carry, sum} = {1'b0, a} + {1'b0, b};
endmodule

// File: rtl/fib_seq_gen.sv
// Loadable Fibonacci/Lucas-type sequence generator with sticky overflow and halt/wrap modes.
// Defining FIB_INDEX_EN adds a step index counter and the index port.
module fib_seq_gen
  import fib_pkg::*;
#(
  parameter int WIDTH       = 32,
  parameter bit STOP_ON_OVF = OVF_STOP
`ifdef FIB_INDEX_EN
  , parameter int IDX_W     = 8
`endif
) (
  input  logic         clk,
  input  logic         rst,
  fib_seq_gen_if.slave bus
);

  fib_state_e       state_q, state_d;
  logic [WIDTH-1:0] out_q, out_d;
  logic [WIDTH-1:0] nxt_q, nxt_d;
  logic             ovf_q, ovf_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] sum;
  logic             carry;
`ifdef FIB_INDEX_EN
  logic [IDX_W-1:0] idx_q, idx_d;
`endif

  fib_step #(.WIDTH(WIDTH)) u_step (
    .a    (out_q),
    .b    (nxt_q),
    .sum  (sum),
    .carry(carry)
  );

  always_comb begin
    state_d = state_q;
    out_d   = out_q;
    nxt_d   = nxt_q;
    ovf_d   = ovf_q;
    done_d  = done_q;
`ifdef FIB_INDEX_EN
    idx_d   = idx_q;
`endif
    if (bus.load) begin
      state_d = RUN;
      out_d   = bus.seed0;
      nxt_d   = bus.seed1;
      ovf_d   = 1'b0;
      done_d  = 1'b0;
`ifdef FIB_INDEX_EN
      idx_d   = '0;
`endif
    end else if (bus.en && state_q == RUN) begin
      out_d = nxt_q;
      nxt_d = sum;
`ifdef FIB_INDEX_EN
      idx_d = idx_q + 1'b1;
`endif
      if (carry) begin
        ovf_d = 1'b1;
        // Halting freezes out on the last term that fit; nxt keeps the truncated sum.
        if (STOP_ON_OVF == OVF_STOP) begin
          state_d = HALT;
          done_d  = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RUN;
      out_q   <= WIDTH'(FIB_SEED0);
      nxt_q   <= WIDTH'(FIB_SEED1);
      ovf_q   <= 1'b0;
      done_q  <= 1'b0;
`ifdef FIB_INDEX_EN
      idx_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      out_q   <= out_d;
      nxt_q   <= nxt_d;
      ovf_q   <= ovf_d;
      done_q  <= done_d;
`ifdef FIB_INDEX_EN
      idx_q   <= idx_d;
`endif
    end
  end

  assign bus.out  = out_q;
  assign bus.nxt  = nxt_q;
  assign bus.ovf  = ovf_q;
  assign bus.done = (STOP_ON_OVF == OVF_STOP) ? done_q : 1'b0;
`ifdef FIB_INDEX_EN
  assign bus.index = idx_q;
`endif

endmodule

// File: tb/tb_fib_seq_gen.sv
// Bench for fib_seq_gen: 8-bit halt, 8-bit wrap and 32-bit halt instances share one control stream.
// Index checks are compiled in when FIB_INDEX_EN is defined.
module tb_fib_seq_gen;

  logic        clk = 1'b0;
  logic        rst, ld, en;
  logic [31:0] s0, s1;
  int          n_cmp = 0;
  int          n_err = 0;

  always #5 clk = ~clk;

  fib_seq_gen_if #(.WIDTH(8))  if8s ();
  fib_seq_gen_if #(.WIDTH(8))  if8w ();
  fib_seq_gen_if #(.WIDTH(32)) if32 ();

  fib_seq_gen #(.WIDTH(8),  .STOP_ON_OVF(1'b1)) u_d8s (.clk(clk), .rst(rst), .bus(if8s.slave));
  fib_seq_gen #(.WIDTH(8),  .STOP_ON_OVF(1'b0)) u_d8w (.clk(clk), .rst(rst), .bus(if8w.slave));
  fib_seq_gen #(.WIDTH(32), .STOP_ON_OVF(1'b1)) u_d32 (.clk(clk), .rst(rst), .bus(if32.slave));

  assign if8s.en = en;  assign if8s.load = ld;  assign if8s.seed0 = s0[7:0]; assign if8s.seed1 = s1[7:0];
  assign if8w.en = en;  assign if8w.load = ld;  assign if8w.seed0 = s0[7:0]; assign if8w.seed1 = s1[7:0];
  assign if32.en = en;  assign if32.load = ld;  assign if32.seed0 = s0;      assign if32.seed1 = s1;

  // Reference model: plain integer arithmetic on 64-bit values.
  typedef struct {
    longint unsigned o, n;
    bit              ovf, done, halt;
    int unsigned     idx;
  } mdl_t;

  mdl_t m8s, m8w, m32;

  function automatic mdl_t mdl_next(mdl_t m, int w, bit stop, bit r, bit l, bit e,
                                    longint unsigned a, longint unsigned b);
    longint unsigned mask = (64'd1 << w) - 1;
    longint unsigned s;
    mdl_t q = m;
    if (r) begin
      q.o = 0; q.n = 1; q.ovf = 0; q.done = 0; q.halt = 0; q.idx = 0;
    end else if (l) begin
      q.o = a & mask; q.n = b & mask; q.ovf = 0; q.done = 0; q.halt = 0; q.idx = 0;
    end else if (e && !m.halt) begin
      s     = m.o + m.n;
      q.o   = m.n;
      q.n   = s & mask;
      q.idx = (m.idx + 1) % 256;
      if (s > mask) begin
        q.ovf = 1;
        if (stop) begin q.halt = 1; q.done = 1; end
      end
    end
    return q;
  endfunction

  // Standalone adder cross-checked against the model's arithmetic.
  logic [31:0] st_a, st_b, st_s;
  logic        st_c;
  assign st_a = m32.o[31:0];
  assign st_b = m32.n[31:0];
  fib_step #(.WIDTH(32)) u_ref_step (.a(st_a), .b(st_b), .sum(st_s), .carry(st_c));

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    m8s = mdl_next(m8s, 8,  1'b1, rst, ld, en, 64'(s0), 64'(s1));
    m8w = mdl_next(m8w, 8,  1'b0, rst, ld, en, 64'(s0), 64'(s1));
    m32 = mdl_next(m32, 32, 1'b1, rst, ld, en, 64'(s0), 64'(s1));
    #1;
  endtask

  task automatic check_all();
    chk("d8s.out", 64'(if8s.out), m8s.o);
    if (!m8s.done) chk("d8s.nxt", 64'(if8s.nxt), m8s.n);
    chk("d8s.ovf", 64'(if8s.ovf), 64'(m8s.ovf));
    chk("d8s.done", 64'(if8s.done), 64'(m8s.done));
    chk("d8w.out", 64'(if8w.out), m8w.o);
    chk("d8w.nxt", 64'(if8w.nxt), m8w.n);
    chk("d8w.ovf", 64'(if8w.ovf), 64'(m8w.ovf));
    chk("d8w.done", 64'(if8w.done), 64'd0);
    chk("d32.out", 64'(if32.out), m32.o);
    if (!m32.done) chk("d32.nxt", 64'(if32.nxt), m32.n);
    chk("d32.ovf", 64'(if32.ovf), 64'(m32.ovf));
    chk("d32.done", 64'(if32.done), 64'(m32.done));
`ifdef FIB_INDEX_EN
    chk("d8s.index", 64'(if8s.index), 64'(m8s.idx));
    chk("d8w.index", 64'(if8w.index), 64'(m8w.idx));
    chk("d32.index", 64'(if32.index), 64'(m32.idx));
`endif
  endtask

  typedef struct {
    bit       rst, ld, en;
    int       a, b;
    logic [7:0] e_out, e_nxt;
    bit       e_ovf, e_done;
  } vec_t;

  vec_t vt[18];
  int   exp8[13];

  initial begin
    vt[0]  = '{1, 0, 0, 0, 0,   0,  1, 0, 0};
    vt[1]  = '{0, 0, 1, 0, 0,   1,  1, 0, 0};
    vt[2]  = '{0, 0, 1, 0, 0,   1,  2, 0, 0};
    vt[3]  = '{0, 0, 1, 0, 0,   2,  3, 0, 0};
    vt[4]  = '{0, 0, 1, 0, 0,   3,  5, 0, 0};
    vt[5]  = '{0, 0, 1, 0, 0,   5,  8, 0, 0};
    vt[6]  = '{0, 0, 1, 0, 0,   8, 13, 0, 0};
    vt[7]  = '{0, 0, 0, 0, 0,   8, 13, 0, 0};
    vt[8]  = '{0, 0, 0, 0, 0,   8, 13, 0, 0};
    vt[9]  = '{0, 0, 1, 0, 0,  13, 21, 0, 0};
    vt[10] = '{0, 1, 1, 2, 1,   2,  1, 0, 0};
    vt[11] = '{0, 0, 1, 0, 0,   1,  3, 0, 0};
    vt[12] = '{0, 0, 1, 0, 0,   3,  4, 0, 0};
    vt[13] = '{0, 0, 1, 0, 0,   4,  7, 0, 0};
    vt[14] = '{0, 0, 1, 0, 0,   7, 11, 0, 0};
    vt[15] = '{0, 0, 1, 0, 0,  11, 18, 0, 0};
    vt[16] = '{0, 0, 1, 0, 0,  18, 29, 0, 0};
    vt[17] = '{1, 1, 1, 2, 1,   0,  1, 0, 0};
    exp8 = '{1, 1, 2, 3, 5, 8, 13, 21, 34, 55, 89, 144, 233};

    rst = 1'b1; ld = 1'b0; en = 1'b0; s0 = '0; s1 = '0;
    m8s = '{0, 1, 0, 0, 0, 0}; m8w = m8s; m32 = m8s;
    tick();

    // Table: reset, stepping, en gating, load-with-en, rst-with-load
    for (int i = 0; i < 18; i++) begin
      rst = vt[i].rst; ld = vt[i].ld; en = vt[i].en;
      s0 = 32'(vt[i].a); s1 = 32'(vt[i].b);
      tick();
      chk($sformatf("vec%0d.out", i),  64'(if8s.out),  64'(vt[i].e_out));
      chk($sformatf("vec%0d.nxt", i),  64'(if8s.nxt),  64'(vt[i].e_nxt));
      chk($sformatf("vec%0d.ovf", i),  64'(if8s.ovf),  64'(vt[i].e_ovf));
      chk($sformatf("vec%0d.done", i), 64'(if8s.done), 64'(vt[i].e_done));
      check_all();
    end

    // Run to 8-bit overflow: halt at 233 in one instance, wrap in the other
    rst = 1'b0; ld = 1'b0; en = 1'b1; s0 = '0; s1 = '0;
    for (int k = 1; k <= 13; k++) begin
      tick();
      chk("run8.out", 64'(if8s.out), 64'(exp8[k-1]));
      chk("run8.done", 64'(if8s.done), 64'(k == 13));
      chk("run8.ovf", 64'(if8s.ovf), 64'(k == 13));
`ifdef FIB_INDEX_EN
      chk("run8.index", 64'(if8s.index), 64'(k));
`endif
      check_all();
    end
    for (int k = 1; k <= 5; k++) begin
      tick();
      chk("halt8.out", 64'(if8s.out), 64'd233);
      chk("halt8.done", 64'(if8s.done), 64'd1);
      if (k == 1) chk("wrap8.out1", 64'(if8w.out), 64'd121);
      if (k == 2) chk("wrap8.out2", 64'(if8w.out), 64'd98);
      chk("wrap8.ovf", 64'(if8w.ovf), 64'd1);
      chk("wrap8.done", 64'(if8w.done), 64'd0);
      check_all();
    end

    // Load while halted, then stepping resumes
    ld = 1'b1; s0 = 32'd2; s1 = 32'd1;
    tick();
    chk("hload.done", 64'(if8s.done), 64'd0);
    chk("hload.out", 64'(if8s.out), 64'd2);
    chk("hload.ovf", 64'(if8s.ovf), 64'd0);
    check_all();
    ld = 1'b0;
    tick();
    chk("hload.step", 64'(if8s.out), 64'd1);
    check_all();

    // 32-bit run from reset to F47
    rst = 1'b1; tick(); check_all();
    rst = 1'b0;
    for (int k = 1; k <= 47; k++) begin
      tick();
      chk("run32.done", 64'(if32.done), 64'(k == 47));
      if (k == 47) begin
        chk("run32.out", 64'(if32.out), 64'd2971215073);
`ifdef FIB_INDEX_EN
        chk("run32.index", 64'(if32.index), 64'd47);
`endif
      end
      check_all();
    end

    // Randomized traffic against the model
    for (int k = 0; k < 400; k++) begin
      rst = ($urandom_range(0, 49) == 0);
      ld  = ($urandom_range(0, 11) == 0);
      en  = ($urandom_range(0, 3) != 0);
      s0  = $urandom_range(0, 1) ? $urandom : $urandom_range(0, 3);
      s1  = $urandom_range(0, 1) ? $urandom : $urandom_range(0, 3);
      tick();
      check_all();
      chk("ref_step", {31'd0, st_c, st_s}, m32.o + m32.n);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
